// File: rtl/leaf_pkt_pkg.sv
// Shared types and constants for the leaf output packetizer.
// Packet layout (default widths): [48]=valid marker, [47:43]=dest leaf,
// [42:39]=dest port, [38:32]=write address, [31:0]=payload.
package leaf_pkt_pkg;

   typedef enum logic [1:0] {
      StUncfg = 2'd0,
      StIdle  = 2'd1,
      StBusy  = 2'd2
   } state_e;

   // Header field widths and bit offsets for the default packet geometry
   localparam int unsigned PayloadW   = 32;
   localparam int unsigned AddrW      = 7;
   localparam int unsigned PortW      = 4;
   localparam int unsigned LeafW      = 5;
   localparam int unsigned PayloadLsb = 0;
   localparam int unsigned AddrLsb    = PayloadLsb + PayloadW;
   localparam int unsigned PortLsb    = AddrLsb + AddrW;
   localparam int unsigned LeafLsb    = PortLsb + PortW;
   localparam int unsigned MarkerBit  = LeafLsb + LeafW;
   localparam int unsigned PacketW    = MarkerBit + 1;

   // Destination buffer depth, i.e. credits available after configuration
   localparam int unsigned CreditMax  = 128;

endpackage

// File: rtl/leaf_credit_counter.sv
// Saturating credit counter: -1 per accepted beat, +IncAmt per credit return,
// load forces the counter back to Max and takes priority over everything.
module leaf_credit_counter
   import leaf_pkt_pkg::*;
#(
   parameter int unsigned Width  = 8,
   parameter int unsigned IncAmt = 64,
   parameter int unsigned Max    = CreditMax
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             dec_i,
   input  logic             inc_i,
   input  logic             load_i,
   output logic [Width-1:0] count_o
);

   logic [Width-1:0] count_q, count_d;
   int unsigned      sum;

   // Next count: apply increment and decrement together, then saturate at Max
   always_comb begin
      sum = 32'(count_q);
      if (inc_i) sum = sum + IncAmt;
      if (dec_i) sum = sum - 1;
      if (sum > Max) sum = Max;
      count_d = load_i ? Width'(Max) : Width'(sum);
   end

   // Counter register, full of credits out of reset
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) count_q <= Width'(Max);
      else         count_q <= count_d;
   end

   assign count_o = count_q;

endmodule

// File: rtl/leaf_out_packetizer.sv
// Wraps user stream beats into BFT packets for the leaf output arbiter,
// stamping destination and a wrapping write address, gated by credits.
// Define LEAF_PKT_STAT_EN to build the sent-packet counter on pkt_count.
module leaf_out_packetizer
   import leaf_pkt_pkg::*;
#(
   parameter int unsigned PACKET_BITS           = PacketW,
   parameter int unsigned PAYLOAD_BITS          = PayloadW,
   parameter int unsigned NUM_LEAF_BITS         = LeafW,
   parameter int unsigned NUM_PORT_BITS         = PortW,
   parameter int unsigned NUM_ADDR_BITS         = AddrW,
   parameter int unsigned FREESPACE_UPDATE_SIZE = 64
) (
   input  logic                     ap_clk,
   input  logic                     ap_rst_n,
   input  logic [PAYLOAD_BITS-1:0]  s_tdata,
   input  logic                     s_tvalid,
   output logic                     s_tready,
   input  logic                     cfg_wr,
   input  logic [NUM_LEAF_BITS-1:0] cfg_dest_leaf,
   input  logic [NUM_PORT_BITS-1:0] cfg_dest_port,
   input  logic                     credit_vld,
   output logic [PACKET_BITS-1:0]   pkt_data,
   output logic                     pkt_vld,
   input  logic                     pkt_ack,
   output logic [31:0]              pkt_count
);

   localparam int unsigned CreditW = NUM_ADDR_BITS + 1;

   state_e                   state_q, state_d;
   logic [PACKET_BITS-1:0]   pkt_q, pkt_d;
   logic [NUM_LEAF_BITS-1:0] leaf_q, leaf_d;
   logic [NUM_PORT_BITS-1:0] port_q, port_d;
   logic [NUM_ADDR_BITS-1:0] addr_q, addr_d;
   logic [CreditW-1:0]       credits;
   logic                     accept;

   leaf_credit_counter #(
      .Width  (CreditW),
      .IncAmt (FREESPACE_UPDATE_SIZE),
      .Max    (2 ** NUM_ADDR_BITS)
   ) u_credit (
      .clk_i   (ap_clk),
      .rst_ni  (ap_rst_n),
      .dec_i   (accept),
      .inc_i   (credit_vld),
      .load_i  (cfg_wr),
      .count_o (credits)
   );

   // Ready only when configured, credited, not reconfiguring, and the holding slot frees now
   always_comb begin
      s_tready = (state_q != StUncfg) && (credits != '0) && !cfg_wr &&
                 ((state_q == StIdle) || pkt_ack);
      accept   = s_tvalid && s_tready;
   end

   // FSM next state; cfg_wr only matters while unconfigured
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StUncfg: if (cfg_wr) state_d = StIdle;
         StIdle:  if (accept) state_d = StBusy;
         StBusy:  if (pkt_ack && !accept) state_d = StIdle;
         default: state_d = StUncfg;
      endcase
   end

   // Datapath next state; a held packet keeps its header across a reconfigure
   always_comb begin
      pkt_d  = accept ? {1'b1, leaf_q, port_q, addr_q, s_tdata} : pkt_q;
      leaf_d = cfg_wr ? cfg_dest_leaf : leaf_q;
      port_d = cfg_wr ? cfg_dest_port : port_q;
      addr_d = addr_q;
      if (cfg_wr)      addr_d = '0;
      else if (accept) addr_d = addr_q + NUM_ADDR_BITS'(1);
   end

   // State and datapath registers
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state_q <= StUncfg;
         pkt_q   <= '0;
         leaf_q  <= '0;
         port_q  <= '0;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         pkt_q   <= pkt_d;
         leaf_q  <= leaf_d;
         port_q  <= port_d;
         addr_q  <= addr_d;
      end
   end

   assign pkt_vld  = (state_q == StBusy);
   assign pkt_data = pkt_q;

`ifdef LEAF_PKT_STAT_EN
   logic [31:0] cnt_q;

   // Count packets handed to the arbiter; wraps naturally
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n)              cnt_q <= '0;
      else if (pkt_vld && pkt_ack) cnt_q <= cnt_q + 32'd1;
   end

   assign pkt_count = cnt_q;
`else
   assign pkt_count = '0;
`endif

endmodule

// File: tb/tb_leaf_out_packetizer.sv
// Self-checking bench for leaf_out_packetizer: directed scenarios plus a
// randomized run, all checked against a transaction-level model.
module tb_leaf_out_packetizer;

   logic        ap_clk = 1'b0;
   logic        ap_rst_n = 1'b0;
   logic [31:0] s_tdata = '0;
   logic        s_tvalid = 1'b0;
   logic        s_tready;
   logic        cfg_wr = 1'b0;
   logic [4:0]  cfg_dest_leaf = '0;
   logic [3:0]  cfg_dest_port = '0;
   logic        credit_vld = 1'b0;
   logic [48:0] pkt_data;
   logic        pkt_vld;
   logic        pkt_ack = 1'b0;
   logic [31:0] pkt_count;

   leaf_out_packetizer dut (
      .ap_clk        (ap_clk),
      .ap_rst_n      (ap_rst_n),
      .s_tdata       (s_tdata),
      .s_tvalid      (s_tvalid),
      .s_tready      (s_tready),
      .cfg_wr        (cfg_wr),
      .cfg_dest_leaf (cfg_dest_leaf),
      .cfg_dest_port (cfg_dest_port),
      .credit_vld    (credit_vld),
      .pkt_data      (pkt_data),
      .pkt_vld       (pkt_vld),
      .pkt_ack       (pkt_ack),
      .pkt_count     (pkt_count)
   );

   always #5 ap_clk = ~ap_clk;

   int n_chk = 0;
   int n_bad = 0;

   // Reference model: configured flag, held packet (if any), credit/address counts
   bit          m_cfgd;
   bit          m_busy;
   logic [48:0] m_held;
   int          m_credits;
   int          m_addr;
   logic [4:0]  m_leaf;
   logic [3:0]  m_port;
   logic [31:0] m_count;

   int accepted;
   int emitted;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   function automatic void model_reset();
      m_cfgd = 0; m_busy = 0; m_held = '0; m_credits = 128; m_addr = 0;
      m_leaf = '0; m_port = '0; m_count = '0;
   endfunction

   task automatic check_outputs();
      check_eq("pkt_vld", {63'd0, pkt_vld}, {63'd0, m_busy});
      if (m_busy) check_eq("pkt_data", {15'd0, pkt_data}, {15'd0, m_held});
`ifdef LEAF_PKT_STAT_EN
      check_eq("pkt_count", {32'd0, pkt_count}, {32'd0, m_count});
`else
      check_eq("pkt_count", {32'd0, pkt_count}, 64'd0);
`endif
   endtask

   // One clock of stimulus: drive at negedge, check, then advance the model
   task automatic step(input bit tv, input logic [31:0] td, input bit cw, input logic [4:0] lf,
                       input logic [3:0] pt, input bit cv, input bit ak);
      bit exp_rdy;
      bit acc;
      @(negedge ap_clk);
      s_tvalid = tv; s_tdata = td; cfg_wr = cw; cfg_dest_leaf = lf; cfg_dest_port = pt;
      credit_vld = cv; pkt_ack = ak;
      #1;
      check_outputs();
      exp_rdy = m_cfgd && (m_credits != 0) && !cw && (!m_busy || ak);
      check_eq("s_tready", {63'd0, s_tready}, {63'd0, exp_rdy});
      acc = tv && exp_rdy;
      if (pkt_vld && ak) emitted++;
      if (acc) accepted++;
      if (m_busy && ak) m_count = m_count + 32'd1;
      if (cw) begin
         m_cfgd = 1; m_leaf = lf; m_port = pt; m_addr = 0; m_credits = 128;
      end else begin
         m_credits = m_credits - (acc ? 1 : 0) + (cv ? 64 : 0);
         if (m_credits > 128) m_credits = 128;
      end
      if (acc) begin
         m_held = {1'b1, m_leaf, m_port, 7'(m_addr), td};
         m_busy = 1;
         if (!cw) m_addr = (m_addr + 1) % 128;
      end else if (m_busy && ak) begin
         m_busy = 0;
      end
   endtask

   // Asynchronous reset pulse landing mid-cycle
   task automatic pulse_reset();
      @(negedge ap_clk);
      s_tvalid = 0; cfg_wr = 0; credit_vld = 0; pkt_ack = 0;
      #2;
      ap_rst_n = 1'b0;
      #1;
      check_eq("rst_vld", {63'd0, pkt_vld}, 64'd0);
      check_eq("rst_rdy", {63'd0, s_tready}, 64'd0);
      check_eq("rst_data", {15'd0, pkt_data}, 64'd0);
      check_eq("rst_count", {32'd0, pkt_count}, 64'd0);
      model_reset();
      @(negedge ap_clk);
      ap_rst_n = 1'b1;
   endtask

   initial begin
      model_reset();
      repeat (2) @(negedge ap_clk);
      #1;
      check_eq("init_vld", {63'd0, pkt_vld}, 64'd0);
      check_eq("init_rdy", {63'd0, s_tready}, 64'd0);
      check_eq("init_data", {15'd0, pkt_data}, 64'd0);
      ap_rst_n = 1'b1;

      // Data offered before any configuration is never taken
      emitted = 0;
      repeat (4) step(1, $urandom, 0, 5'd0, 4'd0, 0, 1);
      check_eq("uncfg_emit", 64'(emitted), 64'd0);

      // Single beat to leaf 3 port 2 with ack tied high
      step(0, 32'd0, 1, 5'd3, 4'd2, 0, 1);
      step(1, 32'hDEADBEEF, 0, 5'd0, 4'd0, 0, 1);
      @(posedge ap_clk);
      #1;
      check_eq("single_data", {15'd0, pkt_data}, 64'h1_1900_DEADBEEF);
      check_eq("single_vld", {63'd0, pkt_vld}, 64'd1);
      step(0, 32'd0, 0, 5'd0, 4'd0, 0, 1);
      step(0, 32'd0, 0, 5'd0, 4'd0, 0, 1);

      // Credit exhaustion after 128 beats, then one credit return reopens 64 slots
      step(0, 32'd0, 1, 5'd17, 4'd9, 0, 1);
      accepted = 0; emitted = 0;
      repeat (130) step(1, $urandom, 0, 5'd0, 4'd0, 0, 1);
      step(0, 32'd0, 0, 5'd0, 4'd0, 0, 1);
      check_eq("dry_accepts", 64'(accepted), 64'd128);
      check_eq("dry_emitted", 64'(emitted), 64'd128);
      check_eq("dry_rdy", {63'd0, s_tready}, 64'd0);
      step(0, 32'd0, 0, 5'd0, 4'd0, 1, 1);
      accepted = 0;
      step(1, 32'h1234_5678, 0, 5'd0, 4'd0, 0, 1);
      @(posedge ap_clk);
      #1;
      check_eq("wrap_addr", {57'd0, pkt_data[38:32]}, 64'd0);
      repeat (69) step(1, $urandom, 0, 5'd0, 4'd0, 0, 1);
      check_eq("refill_accepts", 64'(accepted), 64'd64);

      // Backpressure: ack low holds the packet and blocks new beats
      step(0, 32'd0, 1, 5'd6, 4'd1, 0, 1);
      step(1, $urandom, 0, 5'd0, 4'd0, 0, 1);
      repeat (5) step(1, $urandom, 0, 5'd0, 4'd0, 0, 0);
      step(1, 32'hCAFE_F00D, 0, 5'd0, 4'd0, 0, 1);
      check_eq("ack_accept", {63'd0, s_tready}, 64'd1);
      step(0, 32'd0, 0, 5'd0, 4'd0, 0, 1);

      // Credits at 127 with accept and return together saturate at 128
      step(0, 32'd0, 1, 5'd2, 4'd7, 0, 1);
      step(1, $urandom, 0, 5'd0, 4'd0, 0, 1);
      step(1, $urandom, 0, 5'd0, 4'd0, 1, 1);
      accepted = 0;
      repeat (135) step(1, $urandom, 0, 5'd0, 4'd0, 0, 1);
      check_eq("sat_accepts", 64'(accepted), 64'd128);

      // Reset while a packet is held drops it
      step(0, 32'd0, 1, 5'd9, 4'd3, 0, 1);
      step(1, $urandom, 0, 5'd0, 4'd0, 0, 0);
      step(0, 32'd0, 0, 5'd0, 4'd0, 0, 0);
      pulse_reset();
      emitted = 0;
      repeat (3) step(1, $urandom, 0, 5'd0, 4'd0, 0, 1);
      check_eq("post_rst_emit", 64'(emitted), 64'd0);

      // Randomized traffic
      step(0, 32'd0, 1, 5'($urandom), 4'($urandom), 0, 1);
      for (int i = 0; i < 2000; i++) begin
         step(($urandom % 4) != 0, $urandom, ($urandom % 48) == 0, 5'($urandom), 4'($urandom),
              ($urandom % 8) == 0, ($urandom % 3) != 0);
      end
      pulse_reset();

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
